arm_hazard_unit: RTL and testbench
==================================

Name: arm_hazard_unit

Overview:
- Hazard and forwarding scheduler for the 5-stage pipelined ARM core (F/D/E/M/W).
- Keeps its own lock-step shadow of the E/M/W pipeline registers: source regs, destination reg, RegWrite, MemtoReg.
- From that state and the decode-stage fields it drives:
  - forwarding selects to the execute-stage ALU operand muxes;
  - stall enables for the F and D pipeline registers;
  - flush controls for the D and E pipeline registers.

Parameters:
- REG_W, 4, register-address width (16 architectural registers).
- PC_REG, 15, register index that is never forwarded or hazard-checked (PC reads are supplied by the datapath).
- CNT_W, 16, width of performance counters (used only with HAZARD_PERF_EN).

Ports:
- clk  in  1  core clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- RA1D  in  REG_W  decode-stage source register 1.
- RA2D  in  REG_W  decode-stage source register 2.
- WA3D  in  REG_W  decode-stage destination register.
- RegWriteD  in  1  decode-stage register-write enable.
- MemtoRegD  in  1  decode-stage load indicator (LDR).
- BranchTakenE  in  1  taken branch / BX resolved in execute this cycle.
- StallF  out  1  hold PC register.
- StallD  out  1  hold IF/ID register.
- FlushD  out  1  clear IF/ID register to bubble.
- FlushE  out  1  clear ID/EX register to bubble.
- ForwardAE  out  2  ALU operand A select: 00 = regfile, 01 = W result, 10 = M ALU result.
- ForwardBE  out  2  ALU operand B select, same encoding.

Behaviour:
- Internal stage registers:
  - E stage: RA1E, RA2E, WA3E, RegWriteE, MemtoRegE.
  - M stage: WA3M, RegWriteM.
  - W stage: WA3W, RegWriteW.
- Every rising clk edge, in order of precedence:
  - reset=1: all RegWrite/MemtoReg bits cleared, all address fields set to 0.
  - Otherwise:
    - W <= M and M <= E, unconditionally (M and W never stall).
    - E <= bubble (RegWrite=0, MemtoReg=0, addresses 0) when FlushE=1.
    - Else E <= {RA1D, RA2D, WA3D, RegWriteD, MemtoRegD}.
- Forwarding (combinational from stage regs):
  - ForwardAE = 10 if RegWriteM and WA3M==RA1E and RA1E!=PC_REG.
  - Else 01 if RegWriteW and WA3W==RA1E and RA1E!=PC_REG.
  - Else 00.
  - M has priority over W when both match. ForwardBE uses RA2E with the same rules.
- Load-use hazard: ldrstall = MemtoRegE & RegWriteE & ((RA1D==WA3E & RA1D!=PC_REG) | (RA2D==WA3E & RA2D!=PC_REG)).
- Output equations:
  - StallF = StallD = ldrstall & ~BranchTakenE.
  - FlushD = BranchTakenE.
  - FlushE = ldrstall | BranchTakenE.
- Latency:
  - Load-use inserts exactly one bubble.
  - After a one-cycle stall the LDR sits in M, which is not forwardable for loads. The consumer then reaches E when the LDR is in W and gets ForwardXE=01.
  - Taken branch costs two bubbles (D and E flushed in the same cycle).
- Simultaneous events:
  - BranchTakenE together with ldrstall: the branch wins, with no stall and FlushD=FlushE=1, because the stalled instruction is on the wrong path.
  - Both forwarding sources matching: M is selected.
- Writes with RegWrite=0 never forward or stall, even if addresses match.
- Reset mid-operation:
  - All in-flight shadow state is dropped on the reset edge.
  - While reset=1, outputs are StallF=StallD=0, FlushD=FlushE=1, ForwardAE=ForwardBE=00.
- The shadow pipeline must stay aligned with the datapath's ID/EX, EX/MEM and MEM/WB registers. It uses the same stall/flush it emits.

Optional Feature:
- HAZARD_PERF_EN defined: adds output ports stall_cnt[CNT_W-1:0] and flush_cnt[CNT_W-1:0].
  - stall_cnt increments on every cycle with StallD=1.
  - flush_cnt increments on every cycle with FlushD=1 while reset=0.
  - Both saturate at all-ones and clear to 0 on reset.
- Undefined: ports and counters absent; all other behaviour identical.

Test Plan:
- Back-to-back ALU dependency: ADD R1 (E→M) followed by SUB using R1 as Rn -> ForwardAE=10 the cycle SUB is in E, no stall.
- Two-apart dependency: writer of R2 in W while consumer in E reads R2 as Rm -> ForwardBE=01; writer of R2 in M as well -> ForwardBE=10 (M priority).
- Load-use: LDR R3 in E, decode reads R3 -> StallF=StallD=FlushE=1 for exactly 1 cycle; next cycle consumer in E gets ForwardXE=01; HAZARD_PERF_EN stall_cnt=1.
- Branch taken: BranchTakenE=1 -> FlushD=FlushE=1 for 1 cycle, StallF=0; E holds a bubble next cycle (no forwarding from it).
- Branch and load-use simultaneous, plus PC_REG: BranchTakenE=1 with ldrstall conditions -> StallF=StallD=0, FlushD=FlushE=1; separately writer WA3M=15 with RA1E=15 -> ForwardAE=00.
- Reset mid-stream: assert reset with a load in E and writes in M/W -> after release, all forwards 00, no stall; no forwarding from pre-reset instructions; counters at 0.

Source files
------------

// File: rtl/arm_hazard_unit.sv
// Hazard and forwarding scheduler for a 5-stage ARM pipeline (F/D/E/M/W).
// Define HAZARD_PERF_EN to add saturating stall_cnt / flush_cnt outputs.
module arm_hazard_unit #(
  parameter int unsigned      REG_W  = 4,
  parameter logic [REG_W-1:0] PC_REG = 4'd15,
  parameter int unsigned      CNT_W  = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [REG_W-1:0] RA1D,
  input  logic [REG_W-1:0] RA2D,
  input  logic [REG_W-1:0] WA3D,
  input  logic             RegWriteD,
  input  logic             MemtoRegD,
  input  logic             BranchTakenE,
  output logic             StallF,
  output logic             StallD,
  output logic             FlushD,
  output logic             FlushE,
`ifdef HAZARD_PERF_EN
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
`endif
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE
);

  // A source depends on a producer only if it writes, addresses match and the source is not the PC.
  function automatic logic src_hit(input logic [REG_W-1:0] src,
                                   input logic [REG_W-1:0] dst,
                                   input logic             we);
    return we && (src == dst) && (src != PC_REG);
  endfunction

  // M-stage ALU result is newer than the W-stage result, so it wins.
  function automatic logic [1:0] fwd_sel(input logic [REG_W-1:0] src,
                                         input logic [REG_W-1:0] wa3_m,
                                         input logic             rw_m,
                                         input logic [REG_W-1:0] wa3_w,
                                         input logic             rw_w);
    logic [1:0] sel;
    if (src_hit(src, wa3_m, rw_m)) begin
      sel = 2'b10;
    end else if (src_hit(src, wa3_w, rw_w)) begin
      sel = 2'b01;
    end else begin
      sel = 2'b00;
    end
    return sel;
  endfunction

  logic [REG_W-1:0] ra1_e_q, ra1_e_d;
  logic [REG_W-1:0] ra2_e_q, ra2_e_d;
  logic [REG_W-1:0] wa3_e_q, wa3_e_d;
  logic             rw_e_q, rw_e_d;
  logic             mr_e_q, mr_e_d;
  logic [REG_W-1:0] wa3_m_q, wa3_m_d;
  logic             rw_m_q, rw_m_d;
  logic [REG_W-1:0] wa3_w_q, wa3_w_d;
  logic             rw_w_q, rw_w_d;
  logic             ldrstall_s;

  // Hazard detection and pipeline control outputs.
  always_comb begin
    ldrstall_s = mr_e_q && rw_e_q &&
                 (src_hit(RA1D, wa3_e_q, 1'b1) || src_hit(RA2D, wa3_e_q, 1'b1));
    if (reset) begin
      StallF    = 1'b0;
      StallD    = 1'b0;
      FlushD    = 1'b1;
      FlushE    = 1'b1;
      ForwardAE = 2'b00;
      ForwardBE = 2'b00;
    end else begin
      // A taken branch squashes the stalled instruction, so it overrides the stall.
      StallF    = ldrstall_s && !BranchTakenE;
      StallD    = ldrstall_s && !BranchTakenE;
      FlushD    = BranchTakenE;
      FlushE    = ldrstall_s || BranchTakenE;
      ForwardAE = fwd_sel(ra1_e_q, wa3_m_q, rw_m_q, wa3_w_q, rw_w_q);
      ForwardBE = fwd_sel(ra2_e_q, wa3_m_q, rw_m_q, wa3_w_q, rw_w_q);
    end
  end

  // Shadow pipeline next state: M and W always advance, E takes a bubble on FlushE.
  always_comb begin
    wa3_m_d = wa3_e_q;
    rw_m_d  = rw_e_q;
    wa3_w_d = wa3_m_q;
    rw_w_d  = rw_m_q;
    if (FlushE) begin
      ra1_e_d = '0;
      ra2_e_d = '0;
      wa3_e_d = '0;
      rw_e_d  = 1'b0;
      mr_e_d  = 1'b0;
    end else begin
      ra1_e_d = RA1D;
      ra2_e_d = RA2D;
      wa3_e_d = WA3D;
      rw_e_d  = RegWriteD;
      mr_e_d  = MemtoRegD;
    end
  end

  // Shadow pipeline registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      ra1_e_q <= '0;
      ra2_e_q <= '0;
      wa3_e_q <= '0;
      rw_e_q  <= 1'b0;
      mr_e_q  <= 1'b0;
      wa3_m_q <= '0;
      rw_m_q  <= 1'b0;
      wa3_w_q <= '0;
      rw_w_q  <= 1'b0;
    end else begin
      ra1_e_q <= ra1_e_d;
      ra2_e_q <= ra2_e_d;
      wa3_e_q <= wa3_e_d;
      rw_e_q  <= rw_e_d;
      mr_e_q  <= mr_e_d;
      wa3_m_q <= wa3_m_d;
      rw_m_q  <= rw_m_d;
      wa3_w_q <= wa3_w_d;
      rw_w_q  <= rw_w_d;
    end
  end

`ifdef HAZARD_PERF_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  // Saturating event counters; FlushD is forced high during reset but reset also clears.
  always_comb begin
    if (StallD && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
    if (FlushD && (flush_cnt_q != {CNT_W{1'b1}})) begin
      flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end else begin
      flush_cnt_d = flush_cnt_q;
    end
  end

  // Counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_arm_hazard_unit.sv
// Self-checking bench for arm_hazard_unit: directed scenarios plus randomized
// stimulus checked against an instruction-level pipeline model.
module tb_arm_hazard_unit;

  localparam int CNT_MAX = 65535;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] RA1D, RA2D, WA3D;
  logic       RegWriteD, MemtoRegD, BranchTakenE;
  logic       StallF, StallD, FlushD, FlushE;
  logic [1:0] ForwardAE, ForwardBE;
`ifdef HAZARD_PERF_EN
  logic [15:0] stall_cnt, flush_cnt;
`endif

  arm_hazard_unit dut (
    .clk(clk), .reset(reset),
    .RA1D(RA1D), .RA2D(RA2D), .WA3D(WA3D),
    .RegWriteD(RegWriteD), .MemtoRegD(MemtoRegD), .BranchTakenE(BranchTakenE),
    .StallF(StallF), .StallD(StallD), .FlushD(FlushD), .FlushE(FlushE),
`ifdef HAZARD_PERF_EN
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt),
`endif
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] ra1;
    logic [3:0] ra2;
    logic [3:0] wa3;
    logic       rw;
    logic       mr;
  } instr_t;

  instr_t st_e, st_m, st_w;
  logic       x_stall, x_flushd, x_flushe;
  logic [1:0] x_fa, x_fb;
  int         x_scnt, x_fcnt;
  int         n_tests = 0;
  int         n_fail  = 0;
  logic [7:0] got;

  function automatic logic [1:0] m_fwd(input logic [3:0] src, input instr_t m, input instr_t w);
    if (src == 4'd15) return 2'b00;
    if (m.rw && m.wa3 == src) return 2'b10;
    if (w.rw && w.wa3 == src) return 2'b01;
    return 2'b00;
  endfunction

  task automatic model_eval();
    logic ld;
    ld = 1'b0;
    if (st_e.mr && st_e.rw && st_e.wa3 != 4'd15)
      ld = (RA1D == st_e.wa3) || (RA2D == st_e.wa3);
    if (reset) begin
      x_stall = 1'b0; x_flushd = 1'b1; x_flushe = 1'b1; x_fa = 2'b00; x_fb = 2'b00;
    end else begin
      x_stall  = ld && !BranchTakenE;
      x_flushd = BranchTakenE;
      x_flushe = ld || BranchTakenE;
      x_fa     = m_fwd(st_e.ra1, st_m, st_w);
      x_fb     = m_fwd(st_e.ra2, st_m, st_w);
    end
  endtask

  task automatic model_advance();
    instr_t bub;
    bub = '{ra1: 4'd0, ra2: 4'd0, wa3: 4'd0, rw: 1'b0, mr: 1'b0};
    if (reset) begin
      st_e = bub; st_m = bub; st_w = bub;
      x_scnt = 0; x_fcnt = 0;
    end else begin
      if (x_stall && x_scnt < CNT_MAX) x_scnt++;
      if (x_flushd && x_fcnt < CNT_MAX) x_fcnt++;
      st_w = st_m;
      st_m = st_e;
      st_e = x_flushe ? bub : '{ra1: RA1D, ra2: RA2D, wa3: WA3D, rw: RegWriteD, mr: MemtoRegD};
    end
  endtask

  task automatic drive(input logic [3:0] a1, input logic [3:0] a2, input logic [3:0] wa,
                       input logic rw, input logic mr, input logic br);
    RA1D = a1; RA2D = a2; WA3D = wa; RegWriteD = rw; MemtoRegD = mr; BranchTakenE = br;
    #1;
    model_eval();
  endtask

  task automatic tick();
    @(posedge clk);
    model_advance();
    @(negedge clk);
    #1;
    model_eval();
  endtask

  task automatic clear_pipe();
    drive(4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
    repeat (3) tick();
  endtask

  // Output bundle: {StallF, StallD, FlushD, FlushE, ForwardAE, ForwardBE}
  task automatic test_reset();
    reset = 1'b1;
    drive(4'd1, 4'd2, 4'd3, 1'b1, 1'b1, 1'b0);
    got = {StallF, StallD, FlushD, FlushE, ForwardAE, ForwardBE};
    n_tests++; if (got !== 8'b0011_0000) begin n_fail++; $display("FAIL reset_outputs got %b exp %b", got, 8'b0011_0000); end
    tick(); tick();
    reset = 1'b0;
    drive(4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
    got = {StallF, StallD, FlushD, FlushE, ForwardAE, ForwardBE};
    n_tests++; if (got !== 8'b0000_0000) begin n_fail++; $display("FAIL post_reset_idle got %b exp %b", got, 8'b0000_0000); end
`ifdef HAZARD_PERF_EN
    n_tests++; if (stall_cnt !== 16'd0 || flush_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_counters got %0d/%0d exp 0/0", stall_cnt, flush_cnt); end
`endif
  endtask

  task automatic test_back_to_back();
    clear_pipe();
    drive(4'd0, 4'd0, 4'd1, 1'b1, 1'b0, 1'b0); tick();
    drive(4'd1, 4'd5, 4'd6, 1'b1, 1'b0, 1'b0);
    got = {StallF, StallD, FlushD, FlushE, ForwardAE, ForwardBE};
    n_tests++; if (got !== 8'b0000_0000) begin n_fail++; $display("FAIL b2b_no_stall got %b exp %b", got, 8'b0000_0000); end
    tick();
    drive(4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
    got = {StallF, StallD, FlushD, FlushE, ForwardAE, ForwardBE};
    n_tests++; if (got !== 8'b0000_1000) begin n_fail++; $display("FAIL b2b_fwd_m got %b exp %b", got, 8'b0000_1000); end
  endtask

  task automatic test_two_apart();
    clear_pipe();
    drive(4'd0, 4'd0, 4'd2, 1'b1, 1'b0, 1'b0); tick();
    drive(4'd0, 4'd0, 4'd7, 1'b1, 1'b0, 1'b0); tick();
    drive(4'd6, 4'd2, 4'd8, 1'b1, 1'b0, 1'b0); tick();
    drive(4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
    got = {StallF, StallD, FlushD, FlushE, ForwardAE, ForwardBE};
    n_tests++; if (got !== 8'b0000_0001) begin n_fail++; $display("FAIL two_apart_fwd_w got %b exp %b", got, 8'b0000_0001); end
    clear_pipe();
    drive(4'd0, 4'd0, 4'd2, 1'b1, 1'b0, 1'b0); tick();
    drive(4'd0, 4'd0, 4'd2, 1'b1, 1'b0, 1'b0); tick();
    drive(4'd2, 4'd2, 4'd9, 1'b1, 1'b0, 1'b0); tick();
    drive(4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
    got = {StallF, StallD, FlushD, FlushE, ForwardAE, ForwardBE};
    n_tests++; if (got !== 8'b0000_1010) begin n_fail++; $display("FAIL m_priority got %b exp %b", got, 8'b0000_1010); end
    clear_pipe();
    drive(4'd0, 4'd0, 4'd2, 1'b0, 1'b0, 1'b0); tick();
    drive(4'd2, 4'd2, 4'd9, 1'b1, 1'b0, 1'b0); tick();
    drive(4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
    got = {StallF, StallD, FlushD, FlushE, ForwardAE, ForwardBE};
    n_tests++; if (got !== 8'b0000_0000) begin n_fail++; $display("FAIL no_regwrite_fwd got %b exp %b", got, 8'b0000_0000); end
  endtask

  task automatic test_load_use();
    int s0;
    clear_pipe();
    s0 = 0;
`ifdef HAZARD_PERF_EN
    s0 = int'(stall_cnt);
`endif
    drive(4'd0, 4'd0, 4'd3, 1'b1, 1'b1, 1'b0); tick();
    drive(4'd3, 4'd9, 4'd4, 1'b1, 1'b0, 1'b0);
    got = {StallF, StallD, FlushD, FlushE, ForwardAE, ForwardBE};
    n_tests++; if (got !== 8'b1101_0000) begin n_fail++; $display("FAIL ldr_stall got %b exp %b", got, 8'b1101_0000); end
    tick();
    got = {StallF, StallD, FlushD, FlushE, ForwardAE, ForwardBE};
    n_tests++; if (got !== 8'b0000_0000) begin n_fail++; $display("FAIL ldr_one_bubble got %b exp %b", got, 8'b0000_0000); end
    tick();
    drive(4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
    got = {StallF, StallD, FlushD, FlushE, ForwardAE, ForwardBE};
    n_tests++; if (got !== 8'b0000_0100) begin n_fail++; $display("FAIL ldr_fwd_w got %b exp %b", got, 8'b0000_0100); end
`ifdef HAZARD_PERF_EN
    n_tests++; if (int'(stall_cnt) !== s0 + 1) begin n_fail++; $display("FAIL ldr_stall_cnt got %0d exp %0d", stall_cnt, s0 + 1); end
`endif
    if (s0 < 0) $display("unreachable");
  endtask

  task automatic test_branch();
    int f0;
    clear_pipe();
    f0 = 0;
`ifdef HAZARD_PERF_EN
    f0 = int'(flush_cnt);
`endif
    drive(4'd0, 4'd0, 4'd4, 1'b1, 1'b0, 1'b1);
    got = {StallF, StallD, FlushD, FlushE, ForwardAE, ForwardBE};
    n_tests++; if (got !== 8'b0011_0000) begin n_fail++; $display("FAIL branch_flush got %b exp %b", got, 8'b0011_0000); end
    tick();
    drive(4'd4, 4'd4, 4'd5, 1'b1, 1'b0, 1'b0); tick();
    drive(4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
    got = {StallF, StallD, FlushD, FlushE, ForwardAE, ForwardBE};
    n_tests++; if (got !== 8'b0000_0000) begin n_fail++; $display("FAIL branch_bubble_nofwd got %b exp %b", got, 8'b0000_0000); end
`ifdef HAZARD_PERF_EN
    n_tests++; if (int'(flush_cnt) !== f0 + 1) begin n_fail++; $display("FAIL branch_flush_cnt got %0d exp %0d", flush_cnt, f0 + 1); end
`endif
    if (f0 < 0) $display("unreachable");
  endtask

  task automatic test_branch_ldr_pc();
    clear_pipe();
    drive(4'd0, 4'd0, 4'd3, 1'b1, 1'b1, 1'b0); tick();
    drive(4'd3, 4'd0, 4'd5, 1'b1, 1'b0, 1'b1);
    got = {StallF, StallD, FlushD, FlushE, ForwardAE, ForwardBE};
    n_tests++; if (got !== 8'b0011_0000) begin n_fail++; $display("FAIL branch_beats_ldr got %b exp %b", got, 8'b0011_0000); end
    clear_pipe();
    drive(4'd0, 4'd0, 4'd15, 1'b1, 1'b0, 1'b0); tick();
    drive(4'd15, 4'd15, 4'd1, 1'b1, 1'b0, 1'b0); tick();
    drive(4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
    got = {StallF, StallD, FlushD, FlushE, ForwardAE, ForwardBE};
    n_tests++; if (got !== 8'b0000_0000) begin n_fail++; $display("FAIL pc_no_fwd got %b exp %b", got, 8'b0000_0000); end
    clear_pipe();
    drive(4'd0, 4'd0, 4'd15, 1'b1, 1'b1, 1'b0); tick();
    drive(4'd15, 4'd15, 4'd0, 1'b0, 1'b0, 1'b0);
    got = {StallF, StallD, FlushD, FlushE, ForwardAE, ForwardBE};
    n_tests++; if (got !== 8'b0000_0000) begin n_fail++; $display("FAIL pc_no_stall got %b exp %b", got, 8'b0000_0000); end
  endtask

  task automatic test_reset_mid();
    clear_pipe();
    drive(4'd0, 4'd0, 4'd1, 1'b1, 1'b0, 1'b0); tick();
    drive(4'd0, 4'd0, 4'd2, 1'b1, 1'b0, 1'b0); tick();
    drive(4'd0, 4'd0, 4'd3, 1'b1, 1'b1, 1'b0); tick();
    reset = 1'b1;
    drive(4'd3, 4'd3, 4'd0, 1'b0, 1'b0, 1'b0);
    got = {StallF, StallD, FlushD, FlushE, ForwardAE, ForwardBE};
    n_tests++; if (got !== 8'b0011_0000) begin n_fail++; $display("FAIL mid_reset_outputs got %b exp %b", got, 8'b0011_0000); end
    tick();
    reset = 1'b0;
    drive(4'd3, 4'd1, 4'd0, 1'b0, 1'b0, 1'b0);
    got = {StallF, StallD, FlushD, FlushE, ForwardAE, ForwardBE};
    n_tests++; if (got !== 8'b0000_0000) begin n_fail++; $display("FAIL mid_reset_no_stall got %b exp %b", got, 8'b0000_0000); end
`ifdef HAZARD_PERF_EN
    n_tests++; if (stall_cnt !== 16'd0 || flush_cnt !== 16'd0) begin n_fail++; $display("FAIL mid_reset_counters got %0d/%0d exp 0/0", stall_cnt, flush_cnt); end
`endif
    tick();
    drive(4'd1, 4'd2, 4'd0, 1'b0, 1'b0, 1'b0); tick();
    drive(4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
    got = {StallF, StallD, FlushD, FlushE, ForwardAE, ForwardBE};
    n_tests++; if (got !== 8'b0000_0000) begin n_fail++; $display("FAIL mid_reset_no_fwd got %b exp %b", got, 8'b0000_0000); end
  endtask

  task automatic test_random();
    logic [3:0] pool [5];
    logic [7:0] exp_v;
    pool[0] = 4'd0; pool[1] = 4'd1; pool[2] = 4'd2; pool[3] = 4'd3; pool[4] = 4'd15;
    for (int i = 0; i < 400; i++) begin
      reset = ($urandom_range(0, 39) == 0);
      drive(pool[$urandom_range(0, 4)], pool[$urandom_range(0, 4)], pool[$urandom_range(0, 4)],
            1'($urandom_range(0, 1)), ($urandom_range(0, 2) == 0), ($urandom_range(0, 5) == 0));
      got   = {StallF, StallD, FlushD, FlushE, ForwardAE, ForwardBE};
      exp_v = {x_stall, x_stall, x_flushd, x_flushe, x_fa, x_fb};
      n_tests++; if (got !== exp_v) begin n_fail++; $display("FAIL random_cycle%0d got %b exp %b", i, got, exp_v); end
`ifdef HAZARD_PERF_EN
      n_tests++; if (int'(stall_cnt) !== x_scnt || int'(flush_cnt) !== x_fcnt) begin n_fail++; $display("FAIL random_cnt%0d got %0d/%0d exp %0d/%0d", i, stall_cnt, flush_cnt, x_scnt, x_fcnt); end
`endif
      tick();
    end
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    RA1D = 4'd0; RA2D = 4'd0; WA3D = 4'd0;
    RegWriteD = 1'b0; MemtoRegD = 1'b0; BranchTakenE = 1'b0;
    test_reset();
    test_back_to_back();
    test_two_apart();
    test_load_use();
    test_branch();
    test_branch_ldr_pc();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
